// File: rtl/raw_capture_if.sv
// Pixel-side bundle of raw_capture: sensor timing and control in, qualified pixel stream out.
interface raw_capture_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 11
) ();
    logic [DATA_W-1:0] iDATA;
    logic              iFVAL;
    logic              iLVAL;
    logic              iSTART;
    logic              iEND;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic [31:0]       oFrame_Cont;
    logic              oBusy;

    modport master (
        output iDATA, iFVAL, iLVAL, iSTART, iEND,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
    );

    modport slave (
        input  iDATA, iFVAL, iLVAL, iSTART, iEND,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy
    );
endinterface

// File: rtl/raw_capture.sv
// Raw sensor capture: frame-aligned start/stop, pixel qualify, column/row counters, frame counter.
// Optional crop window when CAPTURE_CROP_EN is defined.
module raw_capture #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned CROP_X0 = 0,
    parameter int unsigned CROP_Y0 = 0,
    parameter int unsigned CROP_W  = 1280,
    parameter int unsigned CROP_H  = 960
) (
    input  logic            iCLK,
    input  logic            iRST,
    raw_capture_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_VBLANK = 2'd1,
        WAIT_FRAME  = 2'd2,
        IN_FRAME    = 2'd3
    } captureState_t;

    localparam logic [CNT_W-1:0] cntMax = {CNT_W{1'b1}};

    // Crop window must be representable by the counters
    if ((CROP_X0 + CROP_W > (2 ** CNT_W)) || (CROP_Y0 + CROP_H > (2 ** CNT_W))) begin : gCropRange
        $error("raw_capture: crop window exceeds counter range");
    end

    captureState_t     state;
    captureState_t     stateNext;

    logic [DATA_W-1:0] rDATA;
    logic              rFVAL;
    logic              rLVAL;
    logic              rFVALd;
    logic              rLVALd;
    logic              runFlag;

    logic [CNT_W-1:0]  xCnt;
    logic [CNT_W-1:0]  yCnt;

    logic              fvalRise_c;
    logic              fvalFall_c;
    logic              frameDone_c;
    logic              enterFrame_c;
    logic              pixQual_c;
    logic              lineEnd_c;
    logic              pixValid_c;
    logic [CNT_W-1:0]  outX_c;
    logic [CNT_W-1:0]  outY_c;

    // Input stage: all control below works on these registered copies
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rDATA  <= '0;
            rFVAL  <= 1'b0;
            rLVAL  <= 1'b0;
            rFVALd <= 1'b0;
            rLVALd <= 1'b0;
        end else begin
            rDATA  <= bus.iDATA;
            rFVAL  <= bus.iFVAL;
            rLVAL  <= bus.iLVAL;
            rFVALd <= rFVAL;
            rLVALd <= rLVAL;
        end
    end

    // Run flag: stop request dominates a simultaneous start
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            runFlag <= 1'b0;
        end else if (bus.iEND) begin
            runFlag <= 1'b0;
        end else if (bus.iSTART) begin
            runFlag <= 1'b1;
        end
    end

    assign fvalRise_c = rFVAL & ~rFVALd;
    assign fvalFall_c = ~rFVAL & rFVALd;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A captured frame always runs to its FVAL fall before run is re-examined
    always_comb begin
        stateNext   = state;
        frameDone_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (runFlag) begin
                    stateNext = WAIT_VBLANK;
                end
            end
            WAIT_VBLANK: begin
                if (!rFVAL) begin
                    stateNext = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!runFlag) begin
                    stateNext = IDLE;
                end else if (fvalRise_c) begin
                    stateNext = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (fvalFall_c) begin
                    frameDone_c = 1'b1;
                    stateNext   = runFlag ? WAIT_FRAME : IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign enterFrame_c = (state != IN_FRAME) && (stateNext == IN_FRAME);
    assign pixQual_c    = (state == IN_FRAME) && rFVAL && rLVAL;
    assign lineEnd_c    = (state == IN_FRAME) && rFVAL && rLVALd && !rLVAL;

    // Raw column/row counters, saturating
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (fvalFall_c || enterFrame_c) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (lineEnd_c) begin
            xCnt <= '0;
            if (yCnt != cntMax) begin
                yCnt <= yCnt + CNT_W'(1);
            end
        end else if (pixQual_c && (xCnt != cntMax)) begin
            xCnt <= xCnt + CNT_W'(1);
        end
    end

`ifdef CAPTURE_CROP_EN
    localparam logic [CNT_W:0] xLo = (CNT_W+1)'(CROP_X0);
    localparam logic [CNT_W:0] xHi = (CNT_W+1)'(CROP_X0 + CROP_W);
    localparam logic [CNT_W:0] yLo = (CNT_W+1)'(CROP_Y0);
    localparam logic [CNT_W:0] yHi = (CNT_W+1)'(CROP_Y0 + CROP_H);

    logic inWin_c;

    assign inWin_c    = ({1'b0, xCnt} >= xLo) && ({1'b0, xCnt} < xHi) &&
                        ({1'b0, yCnt} >= yLo) && ({1'b0, yCnt} < yHi);
    assign pixValid_c = pixQual_c && inWin_c;
    assign outX_c     = xCnt - CNT_W'(CROP_X0);
    assign outY_c     = yCnt - CNT_W'(CROP_Y0);
`else
    assign pixValid_c = pixQual_c;
    assign outX_c     = xCnt;
    assign outY_c     = yCnt;
`endif

    // Output stage: coordinates describe the pixel presented alongside them
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bus.oDATA       <= '0;
            bus.oDVAL       <= 1'b0;
            bus.oX_Cont     <= '0;
            bus.oY_Cont     <= '0;
            bus.oFrame_Cont <= '0;
            bus.oBusy       <= 1'b0;
        end else begin
            bus.oDATA <= rDATA;
            bus.oDVAL <= pixValid_c;
            bus.oBusy <= (state != IDLE);
            if (pixValid_c) begin
                bus.oX_Cont <= outX_c;
                bus.oY_Cont <= outY_c;
            end
            if (frameDone_c) begin
                bus.oFrame_Cont <= bus.oFrame_Cont + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_raw_capture.sv
// Directed bench for raw_capture; build with CAPTURE_CROP_EN defined to exercise the crop window.
module tb_raw_capture;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 11;
`ifdef CAPTURE_CROP_EN
    localparam int unsigned CX0 = 1;
    localparam int unsigned CY0 = 1;
    localparam int unsigned CW  = 2;
    localparam int unsigned CH  = 1;
`else
    localparam int unsigned CX0 = 0;
    localparam int unsigned CY0 = 0;
    localparam int unsigned CW  = 1280;
    localparam int unsigned CH  = 960;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   expFrames = 0;

    // Expected output two cycles behind the drive point
    logic              pvA = 1'b0, pvB = 1'b0;
    logic [DATA_W-1:0] pdA = '0,   pdB = '0;
    logic [CNT_W-1:0]  pxA = '0,   pxB = '0;
    logic [CNT_W-1:0]  pyA = '0,   pyB = '0;

    always #5 clk = ~clk;

    raw_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    raw_capture #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .CROP_X0(CX0),
        .CROP_Y0(CY0),
        .CROP_W (CW),
        .CROP_H (CH)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    task automatic drive_cycle(input logic rstIn, input logic fval, input logic lval,
                               input logic start, input logic stop,
                               input logic [DATA_W-1:0] data, input logic expV,
                               input logic [CNT_W-1:0] expX, input logic [CNT_W-1:0] expY);
        @(negedge clk);
        checks++;
        if (bus.oDVAL !== pvB) begin
            errors++;
            $display("FAIL dval t=%0t got %b want %b", $time, bus.oDVAL, pvB);
        end
        if (pvB) begin
            checks++;
            if (bus.oDATA !== pdB || bus.oX_Cont !== pxB || bus.oY_Cont !== pyB) begin
                errors++;
                $display("FAIL pixel t=%0t got data=%h x=%0d y=%0d want data=%h x=%0d y=%0d",
                         $time, bus.oDATA, bus.oX_Cont, bus.oY_Cont, pdB, pxB, pyB);
            end
        end
        pvB = pvA; pdB = pdA; pxB = pxA; pyB = pyA;
        pvA = expV; pdA = data; pxA = expX; pyA = expY;
        rst        = rstIn;
        bus.iFVAL  = fval;
        bus.iLVAL  = lval;
        bus.iSTART = start;
        bus.iEND   = stop;
        bus.iDATA  = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic send_line(input int line, input int pix, input int base, input logic cap,
                             input int stopCol);
        logic v;
        int   x, y;
        for (int c = 0; c < pix; c++) begin
`ifdef CAPTURE_CROP_EN
            v = cap && (c >= int'(CX0)) && (c < int'(CX0 + CW)) &&
                (line >= int'(CY0)) && (line < int'(CY0 + CH));
            x = c - int'(CX0);
            y = line - int'(CY0);
`else
            v = cap;
            x = (c > 2047) ? 2047 : c;
            y = line;
`endif
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, (c == stopCol),
                        DATA_W'(base + line * pix + c), v, CNT_W'(x), CNT_W'(y));
        end
        repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic frame_begin();
        repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic frame_end();
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic send_frame(input int lines, input int pix, input int base, input logic cap,
                              input int stopLine);
        frame_begin();
        for (int l = 0; l < lines; l++) send_line(l, pix, base, cap, (l == stopLine) ? 1 : -1);
        frame_end();
    endtask

    task automatic pulse_start();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        idle(3);
    endtask

    task automatic check_frames(input string name);
        checks++;
        if (bus.oFrame_Cont !== 32'(expFrames)) begin
            errors++;
            $display("FAIL %s frame_cont got %0d want %0d", name, bus.oFrame_Cont, expFrames);
        end
    endtask

    task automatic check_busy(input string name, input logic want);
        checks++;
        if (bus.oBusy !== want) begin
            errors++;
            $display("FAIL %s busy got %b want %b", name, bus.oBusy, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.oDATA !== '0 || bus.oDVAL !== 1'b0 || bus.oX_Cont !== '0 ||
            bus.oY_Cont !== '0 || bus.oFrame_Cont !== 32'd0 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs got data=%h dval=%b x=%0d y=%0d frames=%0d busy=%b want all 0",
                     name, bus.oDATA, bus.oDVAL, bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont, bus.oBusy);
        end
    endtask

    task automatic test_reset();
        repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 1'b0, '0, '0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        check_all_zero("reset");
        expFrames = 0;
    endtask

    task automatic test_basic_frame();
        pulse_start();
        // LVAL with FVAL low must be ignored
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h7FF, 1'b0, '0, '0);
        idle(1);
        send_frame(3, 4, 'h100, 1'b1, -1);
        expFrames++;
        check_frames("basic");
        check_busy("basic", 1'b1);
    endtask

    task automatic test_stop_boundary();
        send_frame(3, 4, 'h200, 1'b1, 1);
        expFrames++;
        check_frames("stop");
        idle(1);
        check_busy("stop", 1'b0);
        send_frame(3, 4, 'h300, 1'b0, -1);
        check_frames("stop_after");
        check_busy("stop_after", 1'b0);
    endtask

    task automatic test_start_end_same();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_busy("start_end", 1'b0);
        end
        send_frame(2, 3, 'h400, 1'b0, -1);
        check_busy("start_end_frame", 1'b0);
        check_frames("start_end");
    endtask

    task automatic test_mid_frame_start();
        frame_begin();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int l = 0; l < 3; l++) send_line(l, 4, 'h450, 1'b0, -1);
        frame_end();
        check_frames("mid_start_skip");
        check_busy("mid_start", 1'b1);
        send_frame(3, 4, 'h500, 1'b1, -1);
        expFrames++;
        check_frames("mid_start");
    endtask

    task automatic test_x_saturation();
        send_frame(1, 2050, 0, 1'b1, -1);
        expFrames++;
        check_frames("saturation");
    endtask

    task automatic test_reset_mid_frame();
        frame_begin();
        send_line(0, 4, 'h600, 1'b1, -1);
        send_line(1, 4, 'h600, 1'b1, -1);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h608, 1'b1, 11'd0, 11'd2);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h609, 1'b0, '0, '0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h60A, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_all_zero("reset_mid");
        expFrames = 0;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h60B, 1'b0, '0, '0);
        repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        frame_end();
        check_frames("reset_mid_end");
        check_busy("reset_mid_end", 1'b0);
        send_frame(2, 3, 'h700, 1'b0, -1);
        check_frames("reset_no_start");
        pulse_start();
        send_frame(2, 3, 'h800, 1'b1, -1);
        expFrames++;
        check_frames("reset_restart");
    endtask

`ifdef CAPTURE_CROP_EN
    task automatic test_crop();
        pulse_start();
        send_frame(3, 4, 'h100, 1'b1, -1);
        expFrames++;
        check_frames("crop");
    endtask
`endif

    initial begin
        rst        = 1'b1;
        bus.iFVAL  = 1'b0;
        bus.iLVAL  = 1'b0;
        bus.iSTART = 1'b0;
        bus.iEND   = 1'b0;
        bus.iDATA  = '0;
        test_reset();
`ifdef CAPTURE_CROP_EN
        test_crop();
`else
        test_basic_frame();
        test_stop_boundary();
        test_start_end_same();
        test_mid_frame_start();
        test_x_saturation();
        test_reset_mid_frame();
`endif
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
